// File: rtl/cpu_pkg.sv
// Shared definitions for the WISC pipeline control logic.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_pkg;

  // Opcodes the pipeline controller cares about
  localparam logic [3:0] OPC_HLT = 4'b1111;
  localparam logic [3:0] OPC_B   = 4'b1100;
  localparam logic [3:0] OPC_BR  = 4'b1101;

  // Control FSM states: normal flow, draining toward halt, halted
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics.
// Latency: count visible the cycle after inc is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  // Count qualifying cycles, sticking at the maximum value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_flush_ctrl.sv
// Central stall/flush/bubble responder and drain-to-halt sequencer for the 5-stage core.
// Latency: stage controls are combinational from state and inputs; state and counters are registered.
// Backpressure: a D-cache miss freezes every stage; I-cache misses and hazards stall the front end only.
module pipe_stall_flush_ctrl
  import cpu_pkg::*;
#(
  parameter int         CNT_W     = 16,
  parameter int         DRAIN_CYC = 3,
  parameter logic [3:0] HLT_OP    = OPC_HLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_stall,
  input  logic             br_taken,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  input  logic [3:0]       ifid_opcode,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [DW-1:0]   r_drain;
  logic [DW-1:0]   w_drain_nxt;

  logic w_pc_we, w_ifid_we, w_ifid_flush, w_idex_bubble;
  logic w_idex_we, w_exmem_we, w_memwb_we, w_halted;
  logic w_stall_inc, w_flush_inc;

  // State and drain-countdown registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Next state and per-stage controls; everything defaults to a full freeze
  always_comb begin
    w_state_nxt   = r_state;
    w_drain_nxt   = r_drain;
    w_pc_we       = 1'b0;
    w_ifid_we     = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_idex_we     = 1'b0;
    w_exmem_we    = 1'b0;
    w_memwb_we    = 1'b0;
    w_halted      = 1'b0;

    case (r_state)
      RUN: begin
        if (dcache_miss) begin
          // MEM cannot complete: hold the whole pipe, no bubbles
        end else if (hz_stall) begin
          // Hold PC and IF/ID, inject a bubble; any branch here used stale operands
          w_idex_bubble = 1'b1;
          w_idex_we     = 1'b1;
          w_exmem_we    = 1'b1;
          w_memwb_we    = 1'b1;
        end else begin
          w_pc_we    = 1'b1;
          w_ifid_we  = 1'b1;
          w_idex_we  = 1'b1;
          w_exmem_we = 1'b1;
          w_memwb_we = 1'b1;
          if (br_taken) begin
            // Redirect wins over a pending fetch miss: load target, squash fetched slot
            w_ifid_flush = 1'b1;
          end else if (icache_miss) begin
            w_pc_we      = 1'b0;
            w_ifid_flush = 1'b1;
          end
          if (ifid_opcode == HLT_OP) begin
            w_state_nxt = DRAIN;
            w_drain_nxt = DW'(DRAIN_CYC - 1);
          end
        end
      end
      DRAIN: begin
        if (!dcache_miss) begin
          // Stop fetching and let the instructions ahead of HLT retire
          w_idex_bubble = 1'b1;
          w_idex_we     = 1'b1;
          w_exmem_we    = 1'b1;
          w_memwb_we    = 1'b1;
          if (r_drain == '0) begin
            w_state_nxt = HALTED;
          end else begin
            w_drain_nxt = r_drain - DW'(1);
          end
        end
      end
      HALTED: begin
        w_halted = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase

    // While reset is held the pipe loads bubbles and nothing advances
    if (rst) begin
      w_pc_we       = 1'b0;
      w_ifid_we     = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_idex_we     = 1'b0;
      w_exmem_we    = 1'b0;
      w_memwb_we    = 1'b0;
      w_halted      = 1'b0;
    end
  end

  assign pc_we       = w_pc_we;
  assign ifid_we     = w_ifid_we;
  assign ifid_flush  = w_ifid_flush;
  assign idex_bubble = w_idex_bubble;
  assign idex_we     = w_idex_we;
  assign exmem_we    = w_exmem_we;
  assign memwb_we    = w_memwb_we;
  assign halted      = w_halted;

  // A halted core is not "stalled"; flush cycles count whenever IF/ID is squashed
  assign w_stall_inc = !w_pc_we && (r_state != HALTED);
  assign w_flush_inc = w_ifid_flush;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_flush_inc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// Self-checking bench for pipe_stall_flush_ctrl: vector table, corner sequences, random vs model.
// Latency: outputs sampled 1 ns after inputs change at the falling edge.
// Backpressure: n/a.
module tb_pipe_stall_flush_ctrl;

  // Control vector order: {pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_we, halted}
  localparam logic [7:0] C_RST   = 8'h30;
  localparam logic [7:0] C_NORM  = 8'hCE;
  localparam logic [7:0] C_STALL = 8'h1E;
  localparam logic [7:0] C_BR    = 8'hEE;
  localparam logic [7:0] C_IMISS = 8'h6E;
  localparam logic [7:0] C_FRZ   = 8'h00;
  localparam logic [7:0] C_HALT  = 8'h01;
  localparam int         SMALL_MAX = 15;
  localparam int         DRAIN_N   = 3;

  logic clk = 1'b0;
  logic rst, hz_stall, br_taken, icache_miss, dcache_miss;
  logic [3:0] ifid_opcode;

  logic pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_we, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble, s_idex_we, s_exmem_we, s_memwb_we, s_halted;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  logic [7:0] ctrl, ctrl_s;
  assign ctrl   = {pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_we, halted};
  assign ctrl_s = {s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble, s_idex_we, s_exmem_we, s_memwb_we, s_halted};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stall_flush_ctrl dut (
    .clk(clk), .rst(rst), .hz_stall(hz_stall), .br_taken(br_taken),
    .icache_miss(icache_miss), .dcache_miss(dcache_miss), .ifid_opcode(ifid_opcode),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy so saturation is reached in a few cycles
  pipe_stall_flush_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .hz_stall(hz_stall), .br_taken(br_taken),
    .icache_miss(icache_miss), .dcache_miss(dcache_miss), .ifid_opcode(ifid_opcode),
    .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
    .idex_we(s_idex_we), .exmem_we(s_exmem_we), .memwb_we(s_memwb_we), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic       hz, br, ic, dc;
    logic [3:0] op;
    logic [7:0] ctrl;
    int         s, f;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic hz, logic br, logic ic, logic dc, logic [3:0] op,
                              logic [7:0] c, int s, int f);
    vec_t v;
    v.hz = hz; v.br = br; v.ic = ic; v.dc = dc; v.op = op; v.ctrl = c; v.s = s; v.f = f;
    return v;
  endfunction

  function automatic int sat4(int v);
    return (v > SMALL_MAX) ? SMALL_MAX : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] ec, input int es, input int ef);
    check({tag, " ctrl"},    32'(ctrl),        32'(ec));
    check({tag, " ctrl_s"},  32'(ctrl_s),      32'(ec));
    check({tag, " stall"},   32'(stall_cnt),   32'(es));
    check({tag, " flush"},   32'(flush_cnt),   32'(ef));
    check({tag, " stall_s"}, 32'(s_stall_cnt), 32'(sat4(es)));
    check({tag, " flush_s"}, 32'(s_flush_cnt), 32'(sat4(ef)));
  endtask

  task automatic step(input logic hz, input logic br, input logic ic, input logic dc,
                      input logic [3:0] op, input logic [7:0] ec, input int es, input int ef,
                      input string tag);
    @(negedge clk);
    hz_stall = hz; br_taken = br; icache_miss = ic; dcache_miss = dc; ifid_opcode = op;
    #1;
    check_all(tag, ec, es, ef);
  endtask

  task automatic clear_inputs();
    hz_stall = 1'b0; br_taken = 1'b0; icache_miss = 1'b0; dcache_miss = 1'b0; ifid_opcode = 4'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1;
    check_all("reset", C_RST, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset asserted between clock edges must take effect without a clock
  task automatic async_reset(input string tag);
    @(negedge clk);
    clear_inputs();
    #2;
    rst = 1'b1;
    #1;
    check_all(tag, C_RST, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model state
  bit m_halt;
  bit m_in_drain;
  int m_drained;
  int m_s, m_f;

  initial begin
    rst = 1'b1;
    clear_inputs();

    tbl[0]  = mk(0,0,0,0,4'h0, C_NORM,  0, 0);
    tbl[1]  = mk(0,0,0,0,4'h0, C_NORM,  0, 0);
    tbl[2]  = mk(0,0,0,0,4'h0, C_NORM,  0, 0);
    tbl[3]  = mk(0,0,0,0,4'h0, C_NORM,  0, 0);
    tbl[4]  = mk(0,0,0,0,4'h0, C_NORM,  0, 0);
    tbl[5]  = mk(1,1,0,0,4'h0, C_STALL, 0, 0);
    tbl[6]  = mk(0,0,1,0,4'h0, C_IMISS, 1, 0);
    tbl[7]  = mk(0,1,1,0,4'h0, C_BR,    2, 1);
    tbl[8]  = mk(0,0,1,0,4'h0, C_IMISS, 2, 2);
    tbl[9]  = mk(1,0,0,1,4'h0, C_FRZ,   3, 3);
    tbl[10] = mk(1,0,0,1,4'h0, C_FRZ,   4, 3);
    tbl[11] = mk(1,0,0,1,4'h0, C_FRZ,   5, 3);
    tbl[12] = mk(1,0,0,1,4'h0, C_FRZ,   6, 3);
    tbl[13] = mk(0,0,0,0,4'h0, C_NORM,  7, 3);
    tbl[14] = mk(0,0,0,0,4'hF, C_NORM,  7, 3);
    tbl[15] = mk(0,0,0,0,4'h0, C_STALL, 7, 3);
    tbl[16] = mk(0,0,0,0,4'h0, C_STALL, 8, 3);
    tbl[17] = mk(0,0,0,0,4'h0, C_STALL, 9, 3);
    tbl[18] = mk(0,0,0,0,4'h0, C_HALT, 10, 3);
    tbl[19] = mk(1,1,1,1,4'h0, C_HALT, 10, 3);
    tbl[20] = mk(0,0,0,0,4'h0, C_HALT, 10, 3);

    do_reset();
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].hz, tbl[i].br, tbl[i].ic, tbl[i].dc, tbl[i].op, tbl[i].ctrl,
           tbl[i].s, tbl[i].f, $sformatf("vec%0d", i));
    end

    // Leave HALTED only through reset; then drain with a D-cache miss inside
    async_reset("rst_in_halted");
    step(0,0,0,0,4'hF, C_NORM,  0,0, "hlt_enter");
    step(0,0,0,0,4'h0, C_STALL, 0,0, "drain1");
    step(0,0,0,1,4'h0, C_FRZ,   1,0, "drain_dc1");
    step(0,0,0,1,4'h0, C_FRZ,   2,0, "drain_dc2");
    step(0,0,0,0,4'h0, C_STALL, 3,0, "drain2");
    step(0,0,0,0,4'h0, C_STALL, 4,0, "drain3");
    step(0,0,0,0,4'h0, C_HALT,  5,0, "halted6");

    // HLT blocked by a hazard or D-cache miss must not start draining
    do_reset();
    step(1,0,0,0,4'hF, C_STALL, 0,0, "hlt_hz");
    step(0,0,0,1,4'hF, C_FRZ,   1,0, "hlt_dc");
    step(0,1,0,0,4'h0, C_BR,    2,0, "no_drain");
    step(0,0,0,0,4'h0, C_NORM,  2,1, "no_drain2");

    // Reset in the middle of a drain returns to normal flow
    step(0,0,0,0,4'hF, C_NORM,  2,1, "hlt2");
    step(0,0,0,0,4'h0, C_STALL, 2,1, "drain_a");
    async_reset("rst_in_drain");
    step(0,0,0,0,4'h0, C_NORM,  0,0, "after_rst");
    step(0,0,0,0,4'h0, C_NORM,  0,0, "after_rst2");

    // Counter saturation: the 4-bit copy must stick at 15
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(0,0,1,0,4'h0, C_IMISS, i, i, $sformatf("imiss%0d", i));
    end
    step(0,0,0,0,4'h0, C_NORM, 20, 20, "sat_end");

    // Random traffic against the reference model
    do_reset();
    m_halt = 1'b0; m_in_drain = 1'b0; m_drained = 0; m_s = 0; m_f = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] ec;
      logic hz, br, ic, dc;
      logic [3:0] op;
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        #1;
        check_all("rand_rst", C_RST, 0, 0);
        m_halt = 1'b0; m_in_drain = 1'b0; m_drained = 0; m_s = 0; m_f = 0;
        continue;
      end
      rst = 1'b0;
      hz = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 3) == 0);
      ic = ($urandom_range(0, 4) == 0);
      dc = ($urandom_range(0, 5) == 0);
      op = ($urandom_range(0, 24) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      hz_stall = hz; br_taken = br; icache_miss = ic; dcache_miss = dc; ifid_opcode = op;
      #1;

      // Expected controls from the priority rules
      if (m_halt)          ec = C_HALT;
      else if (dc)         ec = C_FRZ;
      else if (m_in_drain) ec = C_STALL;
      else if (hz)         ec = C_STALL;
      else if (br)         ec = C_BR;
      else if (ic)         ec = C_IMISS;
      else                 ec = C_NORM;

      check_all($sformatf("rand%0d", n), ec, m_s, m_f);

      if (!m_halt && !ec[7]) m_s++;
      if (ec[5])             m_f++;

      if (m_halt) begin
        // stays halted
      end else if (m_in_drain) begin
        if (!dc) begin
          m_drained++;
          if (m_drained == DRAIN_N) begin
            m_halt = 1'b1;
            m_in_drain = 1'b0;
          end
        end
      end else if (op == 4'hF && !dc && !hz) begin
        m_in_drain = 1'b1;
        m_drained = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
